traceback_unit: RTL and testbench

- Reads back the per-cell source/zero bits that the processing units write to traceback memory, and walks the alignment path.
- Starts from the max-score cell. Each step emits one direction token (diag/up/left) on a valid/ready stream until a zero-score cell or the matrix edge.
- Sits after the score array and its traceback memory, and feeds the alignment-string formatter.

---
 rtl/traceback_unit.sv | 153 +++++++++++++++
 tb/tb_traceback_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traceback_unit.sv
// Walks the alignment path from the max-score cell and emits one diag/up/left token per cell until a zero-score cell or the matrix edge.
// `define TRACEBACK_ERR_CHECK_EN to flag reserved source codes and out-of-range starts on err.
module traceback_unit #(
  parameter int SOURCE_WIDTH = 2,
  parameter int MAX_ROWS     = 64,
  parameter int MAX_COLS     = 64,
  parameter int ROW_W        = $clog2(MAX_ROWS),
  parameter int COL_W        = $clog2(MAX_COLS),
  parameter int PATH_W       = $clog2(MAX_ROWS + MAX_COLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ROW_W-1:0]        start_row,
  input  logic [COL_W-1:0]        start_col,
  output logic                    busy,
  output logic                    mem_rd_en,
  output logic [ROW_W-1:0]        mem_rd_row,
  output logic [COL_W-1:0]        mem_rd_col,
  input  logic [SOURCE_WIDTH-1:0] mem_rd_source,
  input  logic                    mem_rd_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_dir,
  output logic                    out_last,
  output logic                    done,
  output logic [PATH_W-1:0]       path_len,
  output logic                    err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_END  = 2'b11;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  logic [1:0]         dir_q, dir_d;
  logic               last_q, last_d;
  logic [PATH_W-1:0]  path_len_q, path_len_d;
  logic [1:0]         src;
  logic               start_oob;
`ifdef TRACEBACK_ERR_CHECK_EN
  logic               err_q, err_d;
`endif

  assign src       = mem_rd_source[1:0];
  assign start_oob = (32'(start_row) >= MAX_ROWS) || (32'(start_col) >= MAX_COLS);

  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    dir_d      = dir_q;
    last_d     = last_q;
    path_len_d = path_len_q;
`ifdef TRACEBACK_ERR_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_row_d  = start_row;
          cur_col_d  = start_col;
          path_len_d = '0;
`ifdef TRACEBACK_ERR_CHECK_EN
          err_d      = start_oob;
`endif
          if (start_oob) begin
            dir_d   = DIR_END;
            last_d  = 1'b1;
            state_d = EMIT;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        state_d = EMIT;
        if (mem_rd_zero || src == DIR_END) begin
          dir_d  = DIR_END;
          last_d = 1'b1;
`ifdef TRACEBACK_ERR_CHECK_EN
          if (!mem_rd_zero) err_d = 1'b1;
`endif
        end else begin
          dir_d  = src;
          // Terminate before any move that would step off row 0 or column 0.
          last_d = ((src == DIR_DIAG) && (cur_row_q == '0 || cur_col_q == '0)) ||
                   ((src == DIR_UP)   && (cur_row_q == '0)) ||
                   ((src == DIR_LEFT) && (cur_col_q == '0));
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (dir_q != DIR_END && path_len_q != '1) path_len_d = path_len_q + PATH_W'(1);
          if (last_q) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            if (dir_q != DIR_LEFT) cur_row_d = cur_row_q - ROW_W'(1);
            if (dir_q != DIR_UP)   cur_col_d = cur_col_q - COL_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      dir_q      <= DIR_DIAG;
      last_q     <= 1'b0;
      path_len_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      dir_q      <= dir_d;
      last_q     <= last_d;
      path_len_q <= path_len_d;
    end
  end

`ifdef TRACEBACK_ERR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = (state_q == READ) || (state_q == WAIT) || (state_q == EMIT);
  assign mem_rd_en  = (state_q == READ);
  assign mem_rd_row = cur_row_q;
  assign mem_rd_col = cur_col_q;
  assign out_valid  = (state_q == EMIT);
  assign out_dir    = dir_q;
  assign out_last   = (state_q == EMIT) && last_q;
  assign done       = (state_q == DONE);
  assign path_len   = path_len_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: memory model with one-cycle read latency, stream/read/done monitors, per-scenario checks.
module tb_traceback_unit;
  localparam int MR = 64, MC = 64, RW = 7, CW = 6, PW = 8;
`ifdef TRACEBACK_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0, rst, start, busy, mem_rd_en, mem_rd_zero, out_valid, out_ready, out_last, done, err;
  logic [RW-1:0] start_row, mem_rd_row;
  logic [CW-1:0] start_col, mem_rd_col;
  logic [1:0]    mem_rd_source, out_dir;
  logic [PW-1:0] path_len;

  int npass = 0, ntotal = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int rd_q[$], rd_cyc[$], tok_q[$], tok_cyc[$];
  logic [1:0] msrc  [0:127][0:63];
  logic       mzero [0:127][0:63];

  always #5 clk = ~clk;

  traceback_unit #(.SOURCE_WIDTH(2), .MAX_ROWS(MR), .MAX_COLS(MC), .ROW_W(RW), .COL_W(CW), .PATH_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_row(start_row), .start_col(start_col), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_rd_row(mem_rd_row), .mem_rd_col(mem_rd_col), .mem_rd_source(mem_rd_source),
    .mem_rd_zero(mem_rd_zero), .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
    .out_last(out_last), .done(done), .path_len(path_len), .err(err));

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_source <= msrc[mem_rd_row][mem_rd_col];
      mem_rd_zero   <= mzero[mem_rd_row][mem_rd_col];
    end
  end

  // Monitors see pre-edge values; tokens encoded as last*4+dir, addresses as row*64+col.
  always @(posedge clk) begin
    cyc++;
    if (start) start_cyc = cyc;
    if (mem_rd_en) begin rd_q.push_back(int'(mem_rd_row) * 64 + int'(mem_rd_col)); rd_cyc.push_back(cyc); end
    if (out_valid && out_ready) begin tok_q.push_back(int'(out_last) * 4 + int'(out_dir)); tok_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic do_start(input int r, input int c);
    @(negedge clk); start = 1'b1; start_row = RW'(r); start_col = CW'(c);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (done_cnt > base) ok = 1'b1;
    end
  endtask

  function automatic int tok_at(input int idx);
    return (idx < tok_q.size()) ? tok_q[idx] : -1;
  endfunction

  function automatic int rd_at(input int idx);
    return (idx < rd_q.size()) ? rd_q[idx] : -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start_row = '0; start_col = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    ntotal++; if ({busy, mem_rd_en, out_valid, out_last, done, err} !== 6'b0) $display("FAIL reset_flags got=%b want=000000", {busy, mem_rd_en, out_valid, out_last, done, err}); else npass++;
    ntotal++; if (out_dir !== 2'b00 || path_len !== '0) $display("FAIL reset_dir_len got dir=%b len=%0d want 00/0", out_dir, path_len); else npass++;
    ntotal++; if (mem_rd_row !== '0 || mem_rd_col !== '0) $display("FAIL reset_addr got=%0d,%0d want 0,0", mem_rd_row, mem_rd_col); else npass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_diag;
    int tb0, rb0, db, nt;
    int exp_t[4] = '{0, 0, 0, 7};
    int exp_a[4] = '{3*64+3, 2*64+2, 1*64+1, 0};
    bit ok;
    tb0 = tok_q.size(); rb0 = rd_q.size(); db = done_cnt; out_ready = 1'b1;
    do_start(3, 3);
    wait_done(db, ok);
    ntotal++; if (!ok) $display("FAIL diag_done_timeout got=no_done want=done"); else npass++;
    nt = tok_q.size() - tb0;
    ntotal++; if (nt !== 4) $display("FAIL diag_tok_count got=%0d want=4", nt); else npass++;
    for (int i = 0; i < 4; i++) begin
      ntotal++; if (tok_at(tb0 + i) !== exp_t[i]) $display("FAIL diag_tok%0d got=%0d want=%0d", i, tok_at(tb0 + i), exp_t[i]); else npass++;
      ntotal++; if (rd_at(rb0 + i) !== exp_a[i]) $display("FAIL diag_addr%0d got=%0d want=%0d", i, rd_at(rb0 + i), exp_a[i]); else npass++;
    end
    ntotal++; if (rd_q.size() - rb0 !== 4) $display("FAIL diag_rd_count got=%0d want=4", rd_q.size() - rb0); else npass++;
    if (rd_q.size() - rb0 >= 4) begin
      ntotal++; if (rd_cyc[rb0] - start_cyc !== 1) $display("FAIL diag_first_rd got=%0d want=1", rd_cyc[rb0] - start_cyc); else npass++;
      for (int i = 0; i < 3; i++) begin
        ntotal++; if (rd_cyc[rb0+i+1] - rd_cyc[rb0+i] !== 3) $display("FAIL diag_rd_gap%0d got=%0d want=3", i, rd_cyc[rb0+i+1] - rd_cyc[rb0+i]); else npass++;
      end
    end
    if (nt == 4) begin
      ntotal++; if (done_cyc - tok_cyc[tb0+3] !== 1) $display("FAIL diag_done_lat got=%0d want=1", done_cyc - tok_cyc[tb0+3]); else npass++;
    end
    ntotal++; if (path_len !== PW'(3)) $display("FAIL diag_path_len got=%0d want=3", path_len); else npass++;
    repeat (3) @(negedge clk);
    ntotal++; if (done_cnt - db !== 1 || busy !== 1'b0) $display("FAIL diag_done_pulse got=%0d busy=%b want=1 busy=0", done_cnt - db, busy); else npass++;
    ntotal++; if (path_len !== PW'(3)) $display("FAIL diag_len_stable got=%0d want=3", path_len); else npass++;
  endtask

  task automatic test_left_up;
    int tb0, rb0, db;
    int exp_t[4] = '{2, 1, 0, 5};
    int exp_a[4] = '{2*64+4, 2*64+3, 1*64+3, 0*64+2};
    bit ok;
    tb0 = tok_q.size(); rb0 = rd_q.size(); db = done_cnt; out_ready = 1'b1;
    do_start(2, 4);
    wait_done(db, ok);
    ntotal++; if (!ok) $display("FAIL lu_done_timeout got=no_done want=done"); else npass++;
    ntotal++; if (tok_q.size() - tb0 !== 4) $display("FAIL lu_tok_count got=%0d want=4", tok_q.size() - tb0); else npass++;
    for (int i = 0; i < 4; i++) begin
      ntotal++; if (tok_at(tb0 + i) !== exp_t[i]) $display("FAIL lu_tok%0d got=%0d want=%0d", i, tok_at(tb0 + i), exp_t[i]); else npass++;
      ntotal++; if (rd_at(rb0 + i) !== exp_a[i]) $display("FAIL lu_addr%0d got=%0d want=%0d", i, rd_at(rb0 + i), exp_a[i]); else npass++;
    end
    ntotal++; if (rd_q.size() - rb0 !== 4) $display("FAIL lu_rd_count got=%0d want=4", rd_q.size() - rb0); else npass++;
    ntotal++; if (path_len !== PW'(4)) $display("FAIL lu_path_len got=%0d want=4", path_len); else npass++;
  endtask

  task automatic test_stall;
    int tb0, rb, db;
    bit ok, seen;
    tb0 = tok_q.size(); db = done_cnt; out_ready = 1'b0; seen = 1'b0;
    do_start(3, 3);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    ntotal++; if (!seen) $display("FAIL stall_valid_timeout got=no_valid want=valid"); else npass++;
    rb = rd_q.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ntotal++; if ({out_valid, out_dir, out_last} !== 4'b1000) $display("FAIL stall_hold%0d got=%b want=1000", i, {out_valid, out_dir, out_last}); else npass++;
    end
    ntotal++; if (rd_q.size() !== rb || mem_rd_en !== 1'b0) $display("FAIL stall_no_read got=%0d want=%0d", rd_q.size(), rb); else npass++;
    out_ready = 1'b1;
    wait_done(db, ok);
    ntotal++; if (!ok || tok_q.size() - tb0 !== 4) $display("FAIL stall_complete got=%0d tokens want=4", tok_q.size() - tb0); else npass++;
    ntotal++; if (path_len !== PW'(3)) $display("FAIL stall_path_len got=%0d want=3", path_len); else npass++;
  endtask

  task automatic test_reserved;
    int tb0, db;
    bit ok;
    tb0 = tok_q.size(); db = done_cnt; out_ready = 1'b1;
    msrc[2][2] = 2'b11;
    do_start(2, 2);
    wait_done(db, ok);
    ntotal++; if (!ok || tok_q.size() - tb0 !== 1) $display("FAIL rsv_tok_count got=%0d want=1", tok_q.size() - tb0); else npass++;
    ntotal++; if (tok_at(tb0) !== 7) $display("FAIL rsv_tok got=%0d want=7", tok_at(tb0)); else npass++;
    ntotal++; if (err !== EXP_ERR) $display("FAIL rsv_err got=%b want=%b", err, EXP_ERR); else npass++;
    ntotal++; if (path_len !== '0) $display("FAIL rsv_path_len got=%0d want=0", path_len); else npass++;
    msrc[2][2] = 2'b00;
  endtask

  task automatic test_out_of_range;
    int tb0, rb0, db;
    bit ok;
    tb0 = tok_q.size(); rb0 = rd_q.size(); db = done_cnt; out_ready = 1'b1;
    do_start(64, 0);
    wait_done(db, ok);
    ntotal++; if (!ok) $display("FAIL oob_done_timeout got=no_done want=done"); else npass++;
    ntotal++; if (tok_q.size() - tb0 !== 1 || tok_at(tb0) !== 7) $display("FAIL oob_tok got=%0d n=%0d want=7 n=1", tok_at(tb0), tok_q.size() - tb0); else npass++;
    ntotal++; if (rd_q.size() !== rb0) $display("FAIL oob_no_read got=%0d want=%0d", rd_q.size(), rb0); else npass++;
    ntotal++; if (path_len !== '0) $display("FAIL oob_path_len got=%0d want=0", path_len); else npass++;
    ntotal++; if (err !== EXP_ERR) $display("FAIL oob_err got=%b want=%b", err, EXP_ERR); else npass++;
  endtask

  task automatic test_back_to_back;
    int rb, db;
    bit ok, seen;
    db = done_cnt; out_ready = 1'b1; seen = 1'b0;
    do_start(1, 1);
    ntotal++; if (err !== 1'b0) $display("FAIL b2b_err_clear got=%b want=0", err); else npass++;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    ntotal++; if (!seen) $display("FAIL b2b_done_timeout got=no_done want=done"); else npass++;
    ntotal++; if (path_len !== PW'(1)) $display("FAIL b2b_path_len got=%0d want=1", path_len); else npass++;
    rb = rd_q.size();
    start = 1'b1; start_row = RW'(3); start_col = CW'(3);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    ntotal++; if (busy !== 1'b0 || rd_q.size() !== rb) $display("FAIL b2b_start_on_done busy=%b reads=%0d want busy=0 reads=%0d", busy, rd_q.size(), rb); else npass++;
    db = done_cnt;
    do_start(1, 1);
    wait_done(db, ok);
    ntotal++; if (!ok || path_len !== PW'(1)) $display("FAIL b2b_restart got=%0d want=1", path_len); else npass++;
  endtask

  task automatic test_busy_reset;
    int tb0, rb, db, tr;
    bit ok;
    rb = rd_q.size(); db = done_cnt; out_ready = 1'b1;
    do_start(3, 3);
    do_start(2, 4);
    for (int i = 0; i < 100 && rd_q.size() < rb + 2; i++) @(negedge clk);
    ntotal++; if (rd_at(rb) !== 3*64+3 || rd_at(rb + 1) !== 2*64+2) $display("FAIL busy_start_ignored got=%0d,%0d want=%0d,%0d", rd_at(rb), rd_at(rb + 1), 3*64+3, 2*64+2); else npass++;
    @(negedge clk); rst = 1'b1;
    #1;
    ntotal++; if ({busy, mem_rd_en, out_valid, out_last, done, err} !== 6'b0) $display("FAIL rst_mid_flags got=%b want=000000", {busy, mem_rd_en, out_valid, out_last, done, err}); else npass++;
    ntotal++; if (out_dir !== 2'b00 || path_len !== '0 || mem_rd_row !== '0 || mem_rd_col !== '0) $display("FAIL rst_mid_regs got dir=%b len=%0d want 00/0", out_dir, path_len); else npass++;
    repeat (2) @(negedge clk);
    tr = tok_q.size();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    ntotal++; if (done_cnt !== db || tok_q.size() !== tr) $display("FAIL rst_abort got done=%0d tok=%0d want done=%0d tok=%0d", done_cnt, tok_q.size(), db, tr); else npass++;
    tb0 = tok_q.size();
    do_start(2, 4);
    wait_done(db, ok);
    ntotal++; if (!ok || tok_q.size() - tb0 !== 4 || tok_at(tb0 + 3) !== 5) $display("FAIL rst_fresh_run got=%0d tokens last=%0d want=4 last=5", tok_q.size() - tb0, tok_at(tb0 + 3)); else npass++;
    ntotal++; if (path_len !== PW'(4)) $display("FAIL rst_fresh_len got=%0d want=4", path_len); else npass++;
  endtask

  initial begin
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 64; c++) begin msrc[r][c] = 2'b00; mzero[r][c] = 1'b1; end
    mzero[3][3] = 1'b0; mzero[2][2] = 1'b0; mzero[1][1] = 1'b0;
    msrc[2][4] = 2'b10; mzero[2][4] = 1'b0;
    msrc[2][3] = 2'b01; mzero[2][3] = 1'b0;
    msrc[1][3] = 2'b00; mzero[1][3] = 1'b0;
    msrc[0][2] = 2'b01; mzero[0][2] = 1'b0;
    test_reset();
    test_diag();
    test_left_up();
    test_stall();
    test_reserved();
    test_out_of_range();
    test_back_to_back();
    test_busy_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
